// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: digit register file, slot timer, registered sel/seg drive.
// Optional PWM dimming is compiled in when SEG_SCAN_DIM_EN is defined (adds the dim[3:0] input).
module seg_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEL_ACTIVE_LOW = 1,
    localparam int AW            = $clog2(DIGITS),
    localparam int CW            = $clog2(SCAN_DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              blank,
    input  logic              test,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0]        dim,
`endif
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg,
    output logic [AW-1:0]     scan_idx
);

    localparam logic [CW-1:0]     CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [AW-1:0]     LAST_IDX = AW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     scan_q, scan_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        seg_q, seg_d;
    logic [AW-1:0]     scan_idx_q, scan_idx_d;
    logic              tick;
    logic              drive_on;
    logic [DIGITS-1:0] onehot;
    logic [7:0]        digit_val [DIGITS];

    // One register per digit; an address at or beyond DIGITS matches no slot and is dropped.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [7:0] dig_q, dig_d;

            always_comb begin
                dig_d = dig_q;
                if (wr_en && (wr_addr == AW'(gi))) begin
                    dig_d = wr_data;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dig_q <= 8'h00;
                end else begin
                    dig_q <= dig_d;
                end
            end

            assign digit_val[gi] = dig_q;
        end
    endgenerate

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwm_q, pwm_d;
    logic       pwm_on;

    always_comb begin
        pwm_d  = pwm_q + 4'd1;
        pwm_on = (pwm_q <= dim);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_q <= 4'd0;
        end else begin
            pwm_q <= pwm_d;
        end
    end
`else
    logic pwm_on;
    assign pwm_on = 1'b1;
`endif

    always_comb begin
        tick   = (cnt_q == CNT_MAX);
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        scan_d = scan_q;
        if (tick) begin
            scan_d = (scan_q == LAST_IDX) ? '0 : scan_q + AW'(1);
        end
    end

    // Output stage samples the current scan position, so the pins trail it by one clock.
    always_comb begin
        onehot     = {{(DIGITS-1){1'b0}}, 1'b1} << scan_q;
        drive_on   = !blank && pwm_on;
        scan_idx_d = scan_q;
        sel_d      = SEL_OFF;
        seg_d      = 8'hFF;
        if (drive_on) begin
            sel_d = onehot ^ SEL_OFF;
            seg_d = test ? 8'h00 : ~digit_val[scan_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            scan_q     <= '0;
            sel_q      <= SEL_OFF;
            seg_q      <= 8'hFF;
            scan_idx_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            scan_q     <= scan_d;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign sel      = sel_q;
    assign seg      = seg_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a 4-digit and a 3-digit instance, table vectors plus scoreboard.
module tb_seg_scan_ctrl;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        logic [3:0] exp_sel;
        logic [7:0] exp_seg;
    } vec_t;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        logic [1:0] idx;
        logic [2:0] sel3;
        logic [7:0] seg3;
        logic [1:0] idx3;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, blank, test;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] sel;
    logic [7:0] seg;
    logic [1:0] scan_idx;

    logic       wr_en3, blank3, test3;
    logic [1:0] wr_addr3;
    logic [7:0] wr_data3;
    logic [2:0] sel3;
    logic [7:0] seg3;
    logic [1:0] idx3;

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] dim = 4'hF;
`endif

    int         checks = 0;
    int         errors = 0;
    vec_t       tab [4];
    exp_t       sb_q [$];
    logic [7:0] w3 [4];

    int         m_cnt;
    logic [1:0] m_scan, m_scan3;
    logic [7:0] m_regs [4];
    logic [7:0] m_regs3 [3];

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4), .SEL_ACTIVE_LOW(1)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .blank(blank), .test(test),
`ifdef SEG_SCAN_DIM_EN
        .dim(dim),
`endif
        .sel(sel), .seg(seg), .scan_idx(scan_idx)
    );

    seg_scan_ctrl #(.DIGITS(3), .SCAN_DIV(4), .SEL_ACTIVE_LOW(1)) u_dut3 (
        .clk(clk), .reset(reset), .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .blank(blank3), .test(test3),
`ifdef SEG_SCAN_DIM_EN
        .dim(dim),
`endif
        .sel(sel3), .seg(seg3), .scan_idx(idx3)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_scan  = 2'd0;
        m_scan3 = 2'd0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        for (int i = 0; i < 3; i++) m_regs3[i] = 8'h00;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sel"},  {4'b0, sel},  8'h0F);
        chk({tag, "_seg"},  seg,          8'hFF);
        chk({tag, "_idx"},  {6'b0, scan_idx}, 8'h00);
        chk({tag, "_sel3"}, {5'b0, sel3}, 8'h07);
        chk({tag, "_seg3"}, seg3,         8'hFF);
        chk({tag, "_idx3"}, {6'b0, idx3}, 8'h00);
    endtask

    // Expectation for the coming edge is queued before the edge and retired just after it.
    task automatic step(input bit use_tab, input logic [3:0] tsel, input logic [7:0] tseg);
        exp_t e;
        exp_t g;
        e.sel  = blank ? 4'hF : ~(4'b0001 << m_scan);
        e.seg  = blank ? 8'hFF : (test ? 8'h00 : ~m_regs[m_scan]);
        if (use_tab) begin
            e.sel = tsel;
            e.seg = tseg;
        end
        e.idx  = m_scan;
        e.sel3 = ~(3'b001 << m_scan3);
        e.seg3 = ~m_regs3[m_scan3];
        e.idx3 = m_scan3;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        $display("t=%0t sel=%b seg=%h idx=%0d sel3=%b seg3=%h idx3=%0d", $time, sel, seg, scan_idx, sel3, seg3, idx3);
        chk("sel",  {4'b0, sel},      {4'b0, g.sel});
        chk("seg",  seg,              g.seg);
        chk("idx",  {6'b0, scan_idx}, {6'b0, g.idx});
        chk("sel3", {5'b0, sel3},     {5'b0, g.sel3});
        chk("seg3", seg3,             g.seg3);
        chk("idx3", {6'b0, idx3},     {6'b0, g.idx3});
        if (wr_en) m_regs[wr_addr] = wr_data;
        if (wr_en3 && wr_addr3 < 2'd3) m_regs3[wr_addr3] = wr_data3;
        if (m_cnt == 3) begin
            m_cnt   = 0;
            m_scan  = (m_scan == 2'd3) ? 2'd0 : m_scan + 2'd1;
            m_scan3 = (m_scan3 == 2'd2) ? 2'd0 : m_scan3 + 2'd1;
        end else begin
            m_cnt++;
        end
    endtask

    initial begin
        logic [1:0] tgt;
        reset = 1'b1;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; blank = 1'b0; test = 1'b0;
        wr_en3 = 1'b0; wr_addr3 = 2'd0; wr_data3 = 8'h00; blank3 = 1'b0; test3 = 1'b0;
        tab[0] = '{2'd0, 8'h3F, 4'b1110, 8'hC0};
        tab[1] = '{2'd1, 8'h06, 4'b1101, 8'hF9};
        tab[2] = '{2'd2, 8'h5B, 4'b1011, 8'hA4};
        tab[3] = '{2'd3, 8'h4F, 4'b0111, 8'hB0};
        w3[0] = 8'h11; w3[1] = 8'h22; w3[2] = 8'h33; w3[3] = 8'h5A;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Load digit registers; the 3-digit instance also gets an out-of-range write to addr 3.
        for (int i = 0; i < 4; i++) begin
            wr_en  = 1'b1; wr_addr  = tab[i].addr; wr_data  = tab[i].data;
            wr_en3 = 1'b1; wr_addr3 = 2'(i);       wr_data3 = w3[i];
            step(1'b0, 4'h0, 8'h00);
        end
        wr_en = 1'b0; wr_en3 = 1'b0;

        for (int n = 0; n < 32 && !(m_cnt == 0 && m_scan == 2'd0); n++) step(1'b0, 4'h0, 8'h00);
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) step(1'b1, tab[i].exp_sel, tab[i].exp_seg);

        // Overwrite the digit currently on display.
        for (int n = 0; n < 8 && m_cnt != 0; n++) step(1'b0, 4'h0, 8'h00);
        tgt = m_scan;
        wr_en = 1'b1; wr_addr = tgt; wr_data = 8'h80;
        step(1'b0, 4'h0, 8'h00);
        wr_en = 1'b0;
        step(1'b0, 4'h0, 8'h00);
        chk("live_write_seg", seg, 8'h7F);

        // Write the next digit on the very edge the slot rolls over.
        for (int n = 0; n < 8 && m_cnt != 3; n++) step(1'b0, 4'h0, 8'h00);
        tgt = m_scan + 2'd1;
        wr_en = 1'b1; wr_addr = tgt; wr_data = 8'h99;
        step(1'b0, 4'h0, 8'h00);
        wr_en = 1'b0;
        step(1'b0, 4'h0, 8'h00);
        chk("tick_write_seg", seg, 8'h66);
        chk("tick_write_idx", {6'b0, scan_idx}, {6'b0, tgt});

        blank = 1'b1; test = 1'b1;
        repeat (10) begin
            step(1'b0, 4'h0, 8'h00);
            chk("blank_seg", seg, 8'hFF);
            chk("blank_sel", {4'b0, sel}, 8'h0F);
        end
        blank = 1'b0; test = 1'b0;
        repeat (8) step(1'b0, 4'h0, 8'h00);

        test = 1'b1;
        repeat (8) begin
            step(1'b0, 4'h0, 8'h00);
            chk("test_seg", seg, 8'h00);
        end
        test = 1'b0;
        repeat (16) step(1'b0, 4'h0, 8'h00);

        // Asynchronous reset between edges, with a write pending that must be lost.
        step(1'b0, 4'h0, 8'h00);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h77;
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (16) begin
            step(1'b0, 4'h0, 8'h00);
            chk("cleared_seg", seg, 8'hFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
